// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: active 4x4 keypad scanner with frame-level debouncing.
// One column is driven low at a time. The active-low rows are sampled at the
// end of each column dwell. The four samples form a frame, and the frame is
// classified as NONE, SINGLE or MULTI. A per-frame FSM accepts presses and
// releases after DEBOUNCE_SCANS consecutive agreeing frames.
module keypad_scan_ctrl #(
  parameter int CLK_HZ         = 50000000,
  parameter int SCAN_HZ        = 1000,
  parameter int DEBOUNCE_SCANS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DWELL = CLK_HZ / SCAN_HZ;
  localparam int CW    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int DW    = (DEBOUNCE_SCANS > 0) ? $clog2(DEBOUNCE_SCANS + 1) : 1;

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [DW-1:0] DB_TARGET  = DW'(DEBOUNCE_SCANS);
  localparam logic [DW-1:0] DB_ONE     = DW'(1);

  typedef enum logic [1:0] {
    ST_RELEASED   = 2'd0,
    ST_PRESS_DB   = 2'd1,
    ST_PRESSED    = 2'd2,
    ST_RELEASE_DB = 2'd3
  } state_e;

  // Scan timing state
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [3:0]    col_n_q, col_n_d;

  // Frame accumulator: columns 0..2, bit index = col*4 + row, 1 = row low
  logic [11:0]   samp_q;

  // Debounce FSM state and registered outputs
  state_e        state_q;
  logic [3:0]    cand_q;
  logic [DW-1:0] dbc_q;
  logic [3:0]    key_code_q;
  logic          key_valid_q;
  logic          key_held_q;

  // Frame classification
  logic          sample_s;
  logic          frame_end_s;
  logic [15:0]   frame_s;
  logic [4:0]    ones_s;
  logic [3:0]    pos_s;
  logic          single_s;
  logic          match_s;
  logic [DW-1:0] dbc_sat_s;
  logic          db_done_s;

  // Key code lookup, indexed by {col[1:0], row[1:0]}
  function automatic logic [3:0] key_map(input logic [3:0] pos);
    logic [3:0] code;
    case (pos)
      4'd0:    code = 4'd1;   // r0 c0
      4'd1:    code = 4'd4;   // r1 c0
      4'd2:    code = 4'd7;   // r2 c0
      4'd3:    code = 4'd15;  // r3 c0 '*'
      4'd4:    code = 4'd2;   // r0 c1
      4'd5:    code = 4'd5;   // r1 c1
      4'd6:    code = 4'd8;   // r2 c1
      4'd7:    code = 4'd0;   // r3 c1
      4'd8:    code = 4'd3;   // r0 c2
      4'd9:    code = 4'd6;   // r1 c2
      4'd10:   code = 4'd9;   // r2 c2
      4'd11:   code = 4'd14;  // r3 c2 '#'
      4'd12:   code = 4'd10;  // r0 c3 'A'
      4'd13:   code = 4'd11;  // r1 c3 'B'
      4'd14:   code = 4'd12;  // r2 c3 'C'
      4'd15:   code = 4'd13;  // r3 c3 'D'
      default: code = 4'd0;
    endcase
    return code;
  endfunction

  assign sample_s    = (cnt_q == DWELL_LAST);
  assign frame_end_s = sample_s && (col_idx_q == 2'd3);
  // Column 3 is taken live from the rows at the frame-end sample
  assign frame_s     = {~row_n, samp_q};

  // Next dwell count and column: the count wraps only at the sample point
  always_comb begin
    cnt_d     = cnt_q;
    col_idx_d = col_idx_q;
    if (sample_s) begin
      cnt_d     = '0;
      col_idx_d = col_idx_q + 2'd1;
    end else begin
      cnt_d     = cnt_q + CW'(1);
    end
    col_n_d = ~(4'b0001 << col_idx_d);
  end

  // Scan counter, column index and registered column drive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      col_idx_q <= 2'd0;
      col_n_q   <= 4'b1110;
    end else begin
      cnt_q     <= cnt_d;
      col_idx_q <= col_idx_d;
      col_n_q   <= col_n_d;
    end
  end

  // Capture the settled rows of columns 0..2 into the frame accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_q <= 12'd0;
    end else if (sample_s) begin
      case (col_idx_q)
        2'd0:    samp_q[3:0]  <= ~row_n;
        2'd1:    samp_q[7:4]  <= ~row_n;
        2'd2:    samp_q[11:8] <= ~row_n;
        default: samp_q       <= samp_q;
      endcase
    end else begin
      samp_q <= samp_q;
    end
  end

  // Count the closed contacts in the frame and locate the last one
  always_comb begin
    ones_s = 5'd0;
    pos_s  = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (frame_s[i]) begin
        ones_s = ones_s + 5'd1;
        pos_s  = 4'(i);
      end else begin
        ones_s = ones_s;
      end
    end
  end

  // A frame counts as a key only when exactly one contact is closed;
  // ghosting patterns always have three or more, so they are MULTI
  assign single_s  = (ones_s == 5'd1);
  assign match_s   = single_s && (pos_s == cand_q);
  assign dbc_sat_s = (dbc_q == DB_TARGET) ? dbc_q : (dbc_q + DB_ONE);
  assign db_done_s = (dbc_sat_s == DB_TARGET);

  // Per-frame debounce FSM with registered strobe, held flag and key code
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RELEASED;
      cand_q      <= 4'd0;
      dbc_q       <= '0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (frame_end_s) begin
        case (state_q)
          ST_RELEASED: begin
            if (single_s) begin
              cand_q <= pos_s;
              if (DEBOUNCE_SCANS == 1) begin
                key_code_q  <= key_map(pos_s);
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                dbc_q       <= '0;
                state_q     <= ST_PRESSED;
              end else begin
                dbc_q   <= DB_ONE;
                state_q <= ST_PRESS_DB;
              end
            end else begin
              dbc_q <= '0;
            end
          end
          ST_PRESS_DB: begin
            if (match_s) begin
              if (db_done_s) begin
                key_code_q  <= key_map(cand_q);
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                dbc_q       <= '0;
                state_q     <= ST_PRESSED;
              end else begin
                dbc_q <= dbc_sat_s;
              end
            end else if (single_s) begin
              // A different single key restarts the debounce on that key
              cand_q <= pos_s;
              dbc_q  <= DB_ONE;
            end else begin
              dbc_q   <= '0;
              state_q <= ST_RELEASED;
            end
          end
          ST_PRESSED: begin
            if (!match_s) begin
              if (DEBOUNCE_SCANS == 1) begin
                key_held_q <= 1'b0;
                dbc_q      <= '0;
                state_q    <= ST_RELEASED;
              end else begin
                dbc_q   <= DB_ONE;
                state_q <= ST_RELEASE_DB;
              end
            end else begin
              dbc_q <= '0;
            end
          end
          ST_RELEASE_DB: begin
            if (!match_s) begin
              if (db_done_s) begin
                key_held_q <= 1'b0;
                dbc_q      <= '0;
                state_q    <= ST_RELEASED;
              end else begin
                dbc_q <= dbc_sat_s;
              end
            end else begin
              dbc_q   <= '0;
              state_q <= ST_PRESSED;
            end
          end
          default: begin
            dbc_q   <= '0;
            state_q <= ST_RELEASED;
          end
        endcase
      end else begin
        state_q <= state_q;
      end
    end
  end

  assign col_n     = col_n_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with DWELL=4 (16-cycle frames) and
// DEBOUNCE_SCANS=3. A keypad model closes the pressed switches into the
// rows whenever their column is driven low.
module tb_keypad_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;

  // Pressed switches, bit index = row*4 + col
  logic [15:0] press_mask;

  int checks  = 0;
  int fails   = 0;
  int cyc     = 0;
  int strobes = 0;
  logic prev_valid = 1'b0;

  logic [3:0] col_pat [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  keypad_scan_ctrl #(
    .CLK_HZ        (1000),
    .SCAN_HZ       (250),
    .DEBOUNCE_SCANS(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row_n    (row_n),
    .col_n    (col_n),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  // 10-unit clock period
  always #5 clk = ~clk;

  // Keypad switch matrix: a pressed key pulls its row low when its column is low
  always_comb begin
    row_n = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (press_mask[r*4 + c] && (col_n[c] == 1'b0)) row_n[r] = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n cycles, sampling on the falling edge
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cyc++;
      if (key_valid === 1'b1) strobes++;
      check("valid_not_back_to_back", {7'd0, prev_valid & key_valid}, 8'd0);
      prev_valid = key_valid;
    end
  endtask

  task automatic check_outs(input string tag, input logic v, input logic h, input logic [3:0] code);
    check({tag, "_valid"}, {7'd0, key_valid}, {7'd0, v});
    check({tag, "_held"},  {7'd0, key_held},  {7'd0, h});
    check({tag, "_code"},  {4'd0, key_code},  {4'd0, code});
  endtask

  initial begin
    // ---- 1: reset and idle scan ----
    rst = 1'b1;
    press_mask = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_col", {4'd0, col_n}, 8'h0E);
    check_outs("rst", 1'b0, 1'b0, 4'd0);
    rst = 1'b0;
    cyc = 0;
    #1;
    check("idle_col_c0", {4'd0, col_n}, 8'h0E);
    for (int k = 1; k <= 16; k++) begin
      step(1);
      check("idle_col", {4'd0, col_n}, {4'd0, col_pat[(cyc / 4) % 4]});
      check("idle_valid", {7'd0, key_valid}, 8'd0);
      check("idle_held", {7'd0, key_held}, 8'd0);
    end

    // ---- 2: hold "6" (row 1, col 2) from frame start at cycle 16 ----
    strobes = 0;
    press_mask = 16'h0040;
    step(47);
    check_outs("k6_before", 1'b0, 1'b0, 4'd0);
    check("k6_no_early", strobes[7:0], 8'd0);
    step(1);
    check_outs("k6_accept", 1'b1, 1'b1, 4'd6);
    step(1);
    check_outs("k6_after", 1'b0, 1'b1, 4'd6);
    step(15 + 48);
    check("k6_one_strobe", strobes[7:0], 8'd1);
    check_outs("k6_held", 1'b0, 1'b1, 4'd6);

    // ---- 5a: release "6" at cycle 128 ----
    strobes = 0;
    press_mask = 16'h0000;
    step(47);
    check_outs("rel6_before", 1'b0, 1'b1, 4'd6);
    step(1);
    check_outs("rel6_done", 1'b0, 1'b0, 4'd6);
    check("rel6_no_strobe", strobes[7:0], 8'd0);

    // ---- 3: bouncy "D": 2 frames on, 1 off, 2 on ----
    strobes = 0;
    press_mask = 16'h8000;
    step(32);
    press_mask = 16'h0000;
    step(16);
    press_mask = 16'h8000;
    step(32);
    check_outs("bounceD_mid", 1'b0, 1'b0, 4'd6);
    press_mask = 16'h0000;
    step(16);
    check("bounceD_strobes", strobes[7:0], 8'd0);
    check_outs("bounceD_end", 1'b0, 1'b0, 4'd6);

    // ---- 4: "5" and "9" together for 6 frames ----
    strobes = 0;
    press_mask = 16'h0420;
    step(96);
    check("multi_strobes", strobes[7:0], 8'd0);
    check_outs("multi_end", 1'b0, 1'b0, 4'd6);
    press_mask = 16'h0000;
    step(16);

    // ---- 5b: press "*" (row 3, col 0) at cycle 384, then release ----
    strobes = 0;
    press_mask = 16'h1000;
    step(47);
    check_outs("star_before", 1'b0, 1'b0, 4'd6);
    step(1);
    check_outs("star_accept", 1'b1, 1'b1, 4'd15);
    step(1);
    check_outs("star_after", 1'b0, 1'b1, 4'd15);
    step(15);
    press_mask = 16'h0000;
    step(47);
    check_outs("star_rel_before", 1'b0, 1'b1, 4'd15);
    step(1);
    check_outs("star_rel_done", 1'b0, 1'b0, 4'd15);
    check("star_strobes", strobes[7:0], 8'd1);

    // ---- 6: reset during PRESS_DB of "0" (row 3, col 1) ----
    strobes = 0;
    press_mask = 16'h2000;
    step(34);
    rst = 1'b1;
    #1;
    check("midrst_col", {4'd0, col_n}, 8'h0E);
    check_outs("midrst", 1'b0, 1'b0, 4'd0);
    step(3);
    check("midrst_col_hold", {4'd0, col_n}, 8'h0E);
    rst = 1'b0;
    cyc = 0;
    step(47);
    check_outs("zero_before", 1'b0, 1'b0, 4'd0);
    check("zero_no_early", strobes[7:0], 8'd0);
    step(1);
    check_outs("zero_accept", 1'b1, 1'b1, 4'd0);
    step(1);
    check_outs("zero_after", 1'b0, 1'b1, 4'd0);
    check("zero_strobes", strobes[7:0], 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
